// File: rtl/dreg_pkg.sv
// Shared constants and helpers for the dreg_pipe register pipeline.
package dreg_pkg;

    localparam int MAX_STAGES = 8;

    // Width of the occupancy counter: enough bits to hold 0..stages+skid.
    function automatic int cnt_w(input int stages, input int skid);
        return $clog2(stages + skid + 1);
    endfunction

endpackage

// File: rtl/dti.sv
// Valid/ready data stream bundle used on both sides of dreg_pipe.
interface dti #(
    parameter int W = 16
) ();
    logic [W-1:0] data;
    logic         valid;
    logic         ready;

    modport producer (output data, output valid, input ready);
    modport consumer (input data, input valid, output ready);
endinterface

// File: rtl/dreg_stage.sv
// One pipeline slot: a valid bit plus data word that refills whenever it is
// empty or its current word is leaving, so bubbles collapse toward dout.
module dreg_stage #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         up_valid,
    input  logic [W-1:0] up_data,
    input  logic         dn_ready,
    output logic         valid,
    output logic [W-1:0] data
);
    logic         load_s;
    logic         valid_d;
    logic         valid_q;
    logic [W-1:0] data_d;
    logic [W-1:0] data_q;

    // Next-state for the slot: flush wins, otherwise load whenever ready.
    always_comb begin
        load_s  = ~valid_q | dn_ready;
        valid_d = valid_q;
        data_d  = data_q;
        if (clr) begin
            valid_d = 1'b0;
        end else if (load_s) begin
            valid_d = up_valid;
        end else begin
            valid_d = valid_q;
        end
        if (load_s && up_valid) begin
            data_d = up_data;
        end else begin
            data_d = data_q;
        end
    end

    // Valid bit clears asynchronously on reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Data word carries no reset; it is qualified by valid_q.
    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

    assign valid = valid_q;
    assign data  = data_q;

endmodule

// File: rtl/dreg_pipe.sv
// Bubble-collapsing register pipeline of STAGES slots with an optional skid
// register that makes din.ready independent of dout.ready, plus an
// occupancy counter.
module dreg_pipe
    import dreg_pkg::*;
#(
    parameter int STAGES = 2,
    parameter int SKID   = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           clr,
    dti.consumer                           din,
    dti.producer                           dout,
    output logic [cnt_w(STAGES, SKID)-1:0] cnt
);
    localparam int W  = $bits(din.data);
    localparam int CW = cnt_w(STAGES, SKID);

    if ($bits(dout.data) != W) begin : g_bad_width
        $error("dreg_pipe: dout width %0d differs from din width %0d", $bits(dout.data), W);
    end
    if (STAGES < 1 || STAGES > MAX_STAGES) begin : g_bad_stages
        $error("dreg_pipe: STAGES=%0d outside 1..%0d", STAGES, MAX_STAGES);
    end
    if (SKID != 0 && SKID != 1) begin : g_bad_skid
        $error("dreg_pipe: SKID=%0d must be 0 or 1", SKID);
    end

    logic              src_valid_s;
    logic [W-1:0]      src_data_s;
    logic              din_rdy_s;
    logic [STAGES-1:0] v_s;
    logic [W-1:0]      d_s [STAGES];
    logic [STAGES-1:0] up_v_s;
    logic [W-1:0]      up_d_s [STAGES];
    logic [STAGES:0]   rdy_c;
    logic              in_xfer_s;
    logic              out_xfer_s;
    logic [CW-1:0]     cnt_d;
    logic [CW-1:0]     cnt_q;

    // Ready ripples back from dout: a slot can load if it is empty or the
    // slot after it can load.
    always_comb begin
        rdy_c[STAGES] = dout.ready;
        for (int i = STAGES - 1; i >= 0; i--) begin
            rdy_c[i] = ~v_s[i] | rdy_c[i+1];
        end
    end

    // Upstream source of every slot: slot 0 from din/skid, others from the previous slot.
    always_comb begin
        up_v_s[0] = src_valid_s;
        up_d_s[0] = src_data_s;
        for (int i = 1; i < STAGES; i++) begin
            up_v_s[i] = v_s[i-1];
            up_d_s[i] = d_s[i-1];
        end
    end

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        dreg_stage #(
            .W(W)
        ) u_stage (
            .clk      (clk),
            .rst      (rst),
            .clr      (clr),
            .up_valid (up_v_s[g]),
            .up_data  (up_d_s[g]),
            .dn_ready (rdy_c[g+1]),
            .valid    (v_s[g]),
            .data     (d_s[g])
        );
    end

    if (SKID == 1) begin : g_skid
        logic         skid_valid_d;
        logic         skid_valid_q;
        logic [W-1:0] skid_data_d;
        logic [W-1:0] skid_data_q;

        assign din_rdy_s = rst & ~clr & ~skid_valid_q;

        // Slot 0 drains the skid word before looking at din again; a word
        // accepted while slot 0 is blocked parks in the skid register.
        always_comb begin
            src_valid_s  = skid_valid_q | (din.valid & din_rdy_s);
            src_data_s   = skid_valid_q ? skid_data_q : din.data;
            skid_valid_d = skid_valid_q;
            skid_data_d  = skid_data_q;
            if (clr) begin
                skid_valid_d = 1'b0;
            end else if (skid_valid_q && rdy_c[0]) begin
                skid_valid_d = 1'b0;
            end else if (din.valid && din_rdy_s && !rdy_c[0]) begin
                skid_valid_d = 1'b1;
                skid_data_d  = din.data;
            end else begin
                skid_valid_d = skid_valid_q;
            end
        end

        // Skid valid bit clears asynchronously on reset.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                skid_valid_q <= 1'b0;
            end else begin
                skid_valid_q <= skid_valid_d;
            end
        end

        // Skid data word carries no reset.
        always_ff @(posedge clk) begin
            skid_data_q <= skid_data_d;
        end
    end else begin : g_noskid
        assign din_rdy_s = rst & ~clr & rdy_c[0];

        // Without a skid register din feeds slot 0 directly.
        always_comb begin
            src_valid_s = din.valid & din_rdy_s;
            src_data_s  = din.data;
        end
    end

    // Occupancy tracks accepted minus delivered words; flush empties it.
    always_comb begin
        in_xfer_s  = din.valid & din_rdy_s;
        out_xfer_s = v_s[STAGES-1] & dout.ready;
        if (clr) begin
            cnt_d = {CW{1'b0}};
        end else begin
            cnt_d = cnt_q + CW'(in_xfer_s) - CW'(out_xfer_s);
        end
    end

    // Occupancy register, cleared asynchronously on reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= {CW{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign din.ready  = din_rdy_s;
    assign dout.valid = v_s[STAGES-1];
    assign dout.data  = d_s[STAGES-1];
    assign cnt        = cnt_q;

endmodule

// File: tb/tb_dreg_pipe.sv
// Directed bench for dreg_pipe: a vector table for backpressure, bubble
// collapse and flush, plus hand sequences for streaming, async reset and
// the SKID=0 ready path.
module tb_dreg_pipe;

    typedef struct {
        logic        dv;
        logic [15:0] dd;
        logic        rdy;
        logic        clr;
        logic        ev;
        logic [15:0] ed;
        logic        er;
        logic [2:0]  ec;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       clr;
    logic       clr_b;
    logic [2:0] cnt_a;
    logic [0:0] cnt_b;
    int         total = 0;
    int         bad   = 0;
    vec_t       tbl [23];

    dti #(.W(16)) a_in ();
    dti #(.W(16)) a_out ();
    dti #(.W(16)) b_in ();
    dti #(.W(16)) b_out ();

    dreg_pipe #(.STAGES(3), .SKID(1)) u_a (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .din  (a_in),
        .dout (a_out),
        .cnt  (cnt_a)
    );

    dreg_pipe #(.STAGES(1), .SKID(0)) u_b (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr_b),
        .din  (b_in),
        .dout (b_out),
        .cnt  (cnt_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic dv, input logic [15:0] dd, input logic rdy,
                                input logic cl, input logic ev, input logic [15:0] ed,
                                input logic er, input logic [2:0] ec);
        vec_t v;
        v.dv = dv; v.dd = dd; v.rdy = rdy; v.clr = cl;
        v.ev = ev; v.ed = ed; v.er = er; v.ec = ec;
        return v;
    endfunction

    initial begin
        int          nin;
        int          nout;
        int          nstream;
        logic        exp_v;
        logic [2:0]  exp_c;

        // Backpressure: 5 offered, 4 accepted, then drained in order.
        tbl[0]  = mk(1'b1, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 3'd0);
        tbl[1]  = mk(1'b1, 16'h0002, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 3'd1);
        tbl[2]  = mk(1'b1, 16'h0003, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 3'd2);
        tbl[3]  = mk(1'b1, 16'h0004, 1'b0, 1'b0, 1'b1, 16'h0001, 1'b1, 3'd3);
        tbl[4]  = mk(1'b1, 16'h0005, 1'b0, 1'b0, 1'b1, 16'h0001, 1'b0, 3'd4);
        tbl[5]  = mk(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0001, 1'b0, 3'd4);
        tbl[6]  = mk(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0002, 1'b1, 3'd3);
        tbl[7]  = mk(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0003, 1'b1, 3'd2);
        tbl[8]  = mk(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0004, 1'b1, 3'd1);
        tbl[9]  = mk(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 3'd0);
        // Bubble collapse of a single word, then fill to 4 and flush.
        tbl[10] = mk(1'b1, 16'hBEEF, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 3'd0);
        tbl[11] = mk(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 3'd1);
        tbl[12] = mk(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 3'd1);
        tbl[13] = mk(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'hBEEF, 1'b1, 3'd1);
        tbl[14] = mk(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'hBEEF, 1'b1, 3'd1);
        tbl[15] = mk(1'b1, 16'h0011, 1'b0, 1'b0, 1'b1, 16'hBEEF, 1'b1, 3'd1);
        tbl[16] = mk(1'b1, 16'h0022, 1'b0, 1'b0, 1'b1, 16'hBEEF, 1'b1, 3'd2);
        tbl[17] = mk(1'b1, 16'h0033, 1'b0, 1'b0, 1'b1, 16'hBEEF, 1'b1, 3'd3);
        tbl[18] = mk(1'b1, 16'h0055, 1'b0, 1'b1, 1'b1, 16'hBEEF, 1'b0, 3'd4);
        tbl[19] = mk(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 3'd0);
        tbl[20] = mk(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 3'd0);
        tbl[21] = mk(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 3'd0);
        tbl[22] = mk(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 3'd0);

        rst = 1'b0; clr = 1'b0; clr_b = 1'b0;
        a_in.valid = 1'b0; a_in.data = 16'h0000; a_out.ready = 1'b0;
        b_in.valid = 1'b0; b_in.data = 16'h0000; b_out.ready = 1'b0;

        // Reset state before any clock edge.
        #2;
        chk("reset dout_valid", 32'(a_out.valid), 32'(1'b0));
        chk("reset cnt", 32'(cnt_a), 32'(3'd0));
        chk("reset din_ready", 32'(a_in.ready), 32'(1'b0));
        chk("reset b din_ready", 32'(b_in.ready), 32'(1'b0));
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Table-driven vectors.
        for (int i = 0; i < 23; i++) begin
            a_in.valid  = tbl[i].dv;
            a_in.data   = tbl[i].dd;
            a_out.ready = tbl[i].rdy;
            clr         = tbl[i].clr;
            @(negedge clk);
            chk($sformatf("vec%0d dout_valid", i), 32'(a_out.valid), 32'(tbl[i].ev));
            if (tbl[i].ev) begin
                chk($sformatf("vec%0d dout_data", i), 32'(a_out.data), 32'(tbl[i].ed));
            end
            chk($sformatf("vec%0d din_ready", i), 32'(a_in.ready), 32'(tbl[i].er));
            chk($sformatf("vec%0d cnt", i), 32'(cnt_a), 32'(tbl[i].ec));
            @(posedge clk);
            #1;
        end
        clr = 1'b0;

        // Streaming 0x0001..0x0010 with dout.ready held high.
        nstream = 0;
        for (int c = 0; c < 20; c++) begin
            a_in.valid  = (c < 16);
            a_in.data   = 16'(c + 1);
            a_out.ready = 1'b1;
            @(negedge clk);
            exp_v = (c >= 3 && c <= 18);
            exp_c = (c < 3) ? 3'(c) : ((c <= 16) ? 3'd3 : 3'(19 - c));
            if (c < 16) begin
                chk($sformatf("stream%0d din_ready", c), 32'(a_in.ready), 32'(1'b1));
            end
            chk($sformatf("stream%0d dout_valid", c), 32'(a_out.valid), 32'(exp_v));
            if (exp_v) begin
                chk($sformatf("stream%0d dout_data", c), 32'(a_out.data), 32'(c - 2));
            end
            chk($sformatf("stream%0d cnt", c), 32'(cnt_a), 32'(exp_c));
            if (a_out.valid) begin
                nstream++;
            end
            @(posedge clk);
            #1;
        end
        chk("stream word count", 32'(nstream), 32'(16));

        // Async reset in the middle of a burst.
        for (int c = 0; c < 4; c++) begin
            a_in.valid = 1'b1;
            a_in.data  = 16'(16'h0100 + c);
            @(posedge clk);
            #1;
        end
        #2;
        rst = 1'b0;
        #1;
        chk("async rst dout_valid", 32'(a_out.valid), 32'(1'b0));
        chk("async rst cnt", 32'(cnt_a), 32'(3'd0));
        chk("async rst din_ready", 32'(a_in.ready), 32'(1'b0));
        a_in.valid = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        a_in.valid = 1'b1;
        a_in.data  = 16'h0A0A;
        @(negedge clk);
        chk("post rst din_ready", 32'(a_in.ready), 32'(1'b1));
        chk("post rst dout_valid", 32'(a_out.valid), 32'(1'b0));
        @(posedge clk);
        #1;
        a_in.valid = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk($sformatf("post rst lat%0d valid", k), 32'(a_out.valid), 32'(k == 3));
            if (k == 3) begin
                chk("post rst data", 32'(a_out.data), 32'(16'h0A0A));
            end
            @(posedge clk);
            #1;
        end

        // SKID=0, STAGES=1: full pipe with dout.ready toggling.
        nin  = 0;
        nout = 0;
        b_out.ready = 1'b0;
        b_in.valid  = 1'b1;
        b_in.data   = 16'hB000;
        @(negedge clk);
        if (b_in.ready) begin
            nin++;
        end
        @(posedge clk);
        #1;
        for (int c = 0; c < 16; c++) begin
            b_out.ready = (c % 2 == 1);
            b_in.data   = 16'(16'hB000 + nin);
            @(negedge clk);
            chk($sformatf("skid0 c%0d full", c), 32'(b_out.valid), 32'(1'b1));
            chk($sformatf("skid0 c%0d din_ready", c), 32'(b_in.ready), 32'(c % 2 == 1));
            if (b_out.valid && b_out.ready) begin
                chk($sformatf("skid0 c%0d data", c), 32'(b_out.data), 32'(16'hB000 + nout));
                nout++;
            end
            if (b_in.valid && b_in.ready) begin
                nin++;
            end
            @(posedge clk);
            #1;
        end
        chk("skid0 words out", 32'(nout), 32'(8));
        chk("skid0 words in", 32'(nin), 32'(nout + 1));
        b_in.valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
